sprite_attr_table: RTL and testbench
====================================

SPRITE_ATTR_TABLE -- requirements
Module: sprite_attr_table

Interface
REQ-001 The block SHALL have parameter NUM_SPRITES, default 8: number of sprite attribute slots, 2..32.
REQ-002 The block SHALL have parameter SPRITE_W, default 32: sprite width in pixels, a power of 2.
REQ-003 The block SHALL have parameter SPRITE_H, default 32: sprite height in pixels, a power of 2.
REQ-004 The block SHALL have parameter ADDR_W, default $clog2(NUM_SPRITES)+1: Avalon word-address width.
REQ-005 The block SHALL have port clk, input, 1: the single clock, the VGA pixel clock.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have ports chipselect, write and read, each input, 1: Avalon-MM slave strobes.
REQ-008 The block SHALL have port address, input, ADDR_W: word address.
REQ-009 The block SHALL have port writedata, input, 32: data for 32-bit iowrite32 accesses.
REQ-010 The block SHALL have port readdata, output, 32: registered read data.
REQ-011 The block SHALL have ports VGA_HCOUNT and VGA_VCOUNT, each input, 10: current raster position.
REQ-012 The block SHALL have port hit, output, 1: an enabled sprite covers the pixel.
REQ-013 The block SHALL have port hit_idx, output, $clog2(NUM_SPRITES): index of the winning sprite.
REQ-014 The block SHALL have port addr_t, output, 5+log2(SPRITE_H)+log2(SPRITE_W): sprite ROM address {img, dy, dx}.
REQ-015 The block SHALL have port frame_cnt, output, 8: count of vblank starts.

Function
REQ-016 Addresses 0..NUM_SPRITES-1 SHALL map to shadow attribute words with this layout: [31] enable, [24:20] img, [19:10] x, [9:0] y; all other bits are 0 on readback.
REQ-017 Address NUM_SPRITES SHALL be CTRL: a write with bit0=1 sets commit_pending; a read returns {16'b0, frame_cnt, 7'b0, commit_pending}.
REQ-018 Writes to any address above NUM_SPRITES SHALL be ignored, and reads from them SHALL return 0.
REQ-019 A write SHALL take effect only when chipselect && write are high, and SHALL update the shadow register on the next clk edge.
REQ-020 readdata SHALL be valid on the cycle after chipselect && read (1-cycle read latency), and SHALL hold its value otherwise.
REQ-021 The vblank start event SHALL be the cycle in which VGA_VCOUNT==480 and VGA_HCOUNT==0.
REQ-022 On each vblank start, frame_cnt SHALL increment, wrapping from 255 to 0.
REQ-023 On a vblank start with commit_pending=1, all shadow words SHALL be copied to the active bank and commit_pending SHALL be cleared, in the same edge.
REQ-024 If a shadow write coincides with a commit, the active bank SHALL receive the pre-write shadow value and the shadow register SHALL keep the new value.
REQ-025 If a CTRL commit write coincides with a commit, commit_pending SHALL end the cycle at 1 (the new request wins).
REQ-026 The pixel path SHALL be a 2-stage pipeline in which hit, hit_idx and addr_t correspond to the VGA_HCOUNT/VGA_VCOUNT values sampled 2 cycles earlier.
REQ-027 Stage 1 SHALL compute dx = HCOUNT-x and dy = VCOUNT-y in 11-bit signed arithmetic, for every active sprite, in parallel.
REQ-028 A sprite SHALL be covered when enable=1 and 0<=dx<SPRITE_W and 0<=dy<SPRITE_H; coordinate wrap-around is not a hit.
REQ-029 Stage 2 SHALL priority-encode the covered sprites so that the lowest index wins.
REQ-030 When no sprite is covered, hit SHALL be 0 and hit_idx and addr_t SHALL be 0.
REQ-031 Sprites with x+SPRITE_W>640 or y+SPRITE_H>480 SHALL be clipped naturally by the raster and SHALL NOT be treated as an error.

Reset
REQ-032 While reset=1 at a clk edge, all shadow and active words, commit_pending, frame_cnt, readdata, hit, hit_idx, addr_t and the pipeline registers SHALL be cleared to 0.
REQ-033 Reset asserted mid-frame or mid-commit SHALL take priority over a commit, a write and a frame_cnt increment in the same cycle.

Structure
REQ-034 Package sprite_pkg SHALL hold the attribute struct typedef (enable, img, x, y), the field bit positions, the CTRL bit definitions and the vblank line constant 480.
REQ-035 One sub-module, sprite_hit_unit, SHALL be instantiated NUM_SPRITES times; it takes an attribute and the raster position and produces covered, dx and dy.
REQ-036 The block SHALL contain no RAM macros; both banks SHALL be flops.

Verification
REQ-037 Write slot 0 = {en=1, img=3, x=100, y=50}, commit, and run to vblank, then drive (H=100, V=50) -> 2 cycles later hit=1, hit_idx=0, addr_t={3,0,0}.
REQ-038 With that same state, drive (H=131, V=81) -> hit=1, addr_t={3,31,31}; drive (H=132, V=81) -> hit=0, addr_t=0.
REQ-039 Enable overlapping slots 2 and 5, both at x=200 and y=200, and drive (210, 210) -> hit_idx=2; then disable slot 2 and commit -> hit_idx=5 after the next vblank.
REQ-040 Write slot 1 without a commit -> the active output is unchanged across 3 vblanks, a CTRL read shows pending=0, and frame_cnt advances by 3.
REQ-041 Issue a CTRL commit write and a slot 4 write in the same cycle as the vblank start -> active slot 4 holds the old value and CTRL reads pending=1; the next vblank applies the new value.
REQ-042 Place a sprite at x=630, y=0 and drive H=5 -> no hit (no wrap); assert reset during a commit -> all outputs are 0 and reads return 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite attribute table.
//   sprite_attr_t  : one sprite's attribute record (enable, img, x, y)
//   *_MSB / *_LSB  : bit positions of those fields in the 32-bit bus word
//   CTRL_*         : bit positions inside the CTRL register word
//   VBLANK_LINE    : raster line on which vertical blanking starts
package sprite_pkg;

  typedef struct packed {
    logic       enable;
    logic [4:0] img;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_attr_t;

  localparam int ATTR_EN_BIT = 31;
  localparam int IMG_MSB     = 24;
  localparam int IMG_LSB     = 20;
  localparam int X_MSB       = 19;
  localparam int X_LSB       = 10;
  localparam int Y_MSB       = 9;
  localparam int Y_LSB       = 0;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_FRAME_LSB  = 8;

  localparam logic [9:0] VBLANK_LINE = 10'd480;

  // Bus view of an attribute record; unused word bits read back as 0.
  function automatic logic [31:0] word_from_attr(input sprite_attr_t a);
    logic [31:0] w;
    w = '0;
    w[ATTR_EN_BIT]     = a.enable;
    w[IMG_MSB:IMG_LSB] = a.img;
    w[X_MSB:X_LSB]     = a.x;
    w[Y_MSB:Y_LSB]     = a.y;
    return w;
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// sprite_hit_unit: combinational coverage test for one sprite.
//   attr           : active attribute record of the sprite
//   hcount, vcount : current raster position
//   covered        : sprite enabled and the pixel lies inside its box
//   dx, dy         : 11-bit signed offsets of the pixel from the sprite origin
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  sprite_attr_t       attr,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  output logic               covered,
  output logic signed [10:0] dx,
  output logic signed [10:0] dy
);

  logic [10:0] dx_raw;
  logic [10:0] dy_raw;
  logic        unused_img;

  // Both operands are 10-bit unsigned, so the 11-bit difference never
  // overflows and bit 10 is exactly the sign: a pixel left of / above the
  // origin (including any raster wrap) is negative and never covered.
  assign dx_raw = {1'b0, hcount} - {1'b0, attr.x};
  assign dy_raw = {1'b0, vcount} - {1'b0, attr.y};

  assign dx = $signed(dx_raw);
  assign dy = $signed(dy_raw);

  assign covered = attr.enable
                && !dx_raw[10] && (dx_raw < 11'(SPRITE_W))
                && !dy_raw[10] && (dy_raw < 11'(SPRITE_H));

  assign unused_img = ^attr.img;

endmodule

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: double-buffered sprite attribute table with a 2-stage
// pixel hit pipeline, attached to an Avalon-MM slave port.
//   clk, reset                  : pixel clock, synchronous active-high reset
//   chipselect/write/read       : Avalon strobes
//   address, writedata          : word address and write data
//   readdata                    : registered read data, 1-cycle latency
//   VGA_HCOUNT, VGA_VCOUNT      : raster position
//   hit, hit_idx, addr_t        : winning sprite and its ROM address {img,dy,dx},
//                                 two cycles after the raster position
//   frame_cnt                   : vblank start counter
// Slots 0..NUM_SPRITES-1 are shadow attributes; slot NUM_SPRITES is CTRL.
// Writing CTRL bit0 requests a commit of the shadow bank to the active bank,
// carried out at the next vblank start.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int ADDR_W      = $clog2(NUM_SPRITES) + 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           chipselect,
  input  logic                                           write,
  input  logic                                           read,
  input  logic [ADDR_W-1:0]                              address,
  input  logic [31:0]                                    writedata,
  output logic [31:0]                                    readdata,
  input  logic [9:0]                                     VGA_HCOUNT,
  input  logic [9:0]                                     VGA_VCOUNT,
  output logic                                           hit,
  output logic [$clog2(NUM_SPRITES)-1:0]                 hit_idx,
  output logic [5+$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0] addr_t,
  output logic [7:0]                                     frame_cnt
);

  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int LW    = $clog2(SPRITE_W);
  localparam int LH    = $clog2(SPRITE_H);
  localparam int AT_W  = 5 + LH + LW;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_SPRITES);

  // ---------------- register file ----------------
  sprite_attr_t shadow_reg [NUM_SPRITES];
  sprite_attr_t active_reg [NUM_SPRITES];
  logic         commit_pending_reg;
  logic [7:0]   frame_cnt_reg;
  logic [31:0]  readdata_reg;
  logic [31:0]  read_next;
  sprite_attr_t wr_attr;
  logic         vblank, wr_en, rd_en, slot_sel, ctrl_commit_wr, commit;
  logic         unused_wdata;

  assign vblank         = (VGA_VCOUNT == VBLANK_LINE) && (VGA_HCOUNT == 10'd0);
  assign wr_en          = chipselect && write;
  assign rd_en          = chipselect && read;
  assign slot_sel       = address < CTRL_ADDR;
  assign ctrl_commit_wr = wr_en && (address == CTRL_ADDR) && writedata[CTRL_COMMIT_BIT];
  assign commit         = vblank && commit_pending_reg;

  assign wr_attr.enable = writedata[ATTR_EN_BIT];
  assign wr_attr.img    = writedata[IMG_MSB:IMG_LSB];
  assign wr_attr.x      = writedata[X_MSB:X_LSB];
  assign wr_attr.y      = writedata[Y_MSB:Y_LSB];
  assign unused_wdata   = ^writedata[30:25];

  always_comb begin
    read_next = '0;
    if (slot_sel) begin
      read_next = word_from_attr(shadow_reg[address[IDX_W-1:0]]);
    end else if (address == CTRL_ADDR) begin
      read_next[CTRL_FRAME_LSB +: 8]  = frame_cnt_reg;
      read_next[CTRL_COMMIT_BIT]      = commit_pending_reg;
    end
  end

  // The commit copies the pre-edge shadow contents, so a shadow write in the
  // same cycle lands only in the shadow bank; a CTRL request in the same
  // cycle re-arms commit_pending after the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      commit_pending_reg <= 1'b0;
      frame_cnt_reg      <= 8'd0;
      readdata_reg       <= 32'd0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
      if (wr_en && slot_sel) begin
        shadow_reg[address[IDX_W-1:0]] <= wr_attr;
      end
      if (ctrl_commit_wr) begin
        commit_pending_reg <= 1'b1;
      end else if (commit) begin
        commit_pending_reg <= 1'b0;
      end
      if (vblank) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
      if (rd_en) begin
        readdata_reg <= read_next;
      end
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [NUM_SPRITES-1:0] cov_c;
  logic [LW-1:0]          dx_c [NUM_SPRITES];
  logic [LH-1:0]          dy_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] unused_delta;

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
      logic signed [10:0] dx_full, dy_full;
      sprite_hit_unit #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit (
        .attr    (active_reg[gi]),
        .hcount  (VGA_HCOUNT),
        .vcount  (VGA_VCOUNT),
        .covered (cov_c[gi]),
        .dx      (dx_full),
        .dy      (dy_full)
      );
      // Once covered, only the low bits address the sprite image.
      assign dx_c[gi]         = dx_full[LW-1:0];
      assign dy_c[gi]         = dy_full[LH-1:0];
      assign unused_delta[gi] = ^{dx_full[10:LW], dy_full[10:LH]};
    end
  endgenerate

  logic [NUM_SPRITES-1:0] s1_cov_reg;
  logic [LW-1:0]          s1_dx_reg  [NUM_SPRITES];
  logic [LH-1:0]          s1_dy_reg  [NUM_SPRITES];
  logic [4:0]             s1_img_reg [NUM_SPRITES];
  logic                   hit_reg, hit_next;
  logic [IDX_W-1:0]       hit_idx_reg, hit_idx_next;
  logic [AT_W-1:0]        addr_t_reg, addr_t_next;

  // Walk from the top index down so the lowest covered index is assigned last.
  always_comb begin
    hit_next     = 1'b0;
    hit_idx_next = '0;
    addr_t_next  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (s1_cov_reg[i]) begin
        hit_next     = 1'b1;
        hit_idx_next = IDX_W'(i);
        addr_t_next  = {s1_img_reg[i], s1_dy_reg[i], s1_dx_reg[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_cov_reg <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        s1_dx_reg[i]  <= '0;
        s1_dy_reg[i]  <= '0;
        s1_img_reg[i] <= '0;
      end
      hit_reg     <= 1'b0;
      hit_idx_reg <= '0;
      addr_t_reg  <= '0;
    end else begin
      s1_cov_reg <= cov_c;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        s1_dx_reg[i]  <= dx_c[i];
        s1_dy_reg[i]  <= dy_c[i];
        s1_img_reg[i] <= active_reg[i].img;
      end
      hit_reg     <= hit_next;
      hit_idx_reg <= hit_idx_next;
      addr_t_reg  <= addr_t_next;
    end
  end

  assign readdata  = readdata_reg;
  assign frame_cnt = frame_cnt_reg;
  assign hit       = hit_reg;
  assign hit_idx   = hit_idx_reg;
  assign addr_t    = addr_t_reg;

endmodule

// File: tb/tb_sprite_attr_table.sv
// tb_sprite_attr_table: directed test of sprite_attr_table (default parameters)
// with a behavioural reference model checked on every clock cycle, plus
// hand-computed literal expectations at the interesting points.
module tb_sprite_attr_table;

  localparam int PARK_H = 1000;
  localparam int PARK_V = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, wr, rd;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [9:0]  hcount, vcount;
  logic        hit;
  logic [2:0]  hit_idx;
  logic [14:0] addr_t;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_attr_table dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (cs),
    .write      (wr),
    .read       (rd),
    .address    (addr),
    .writedata  (wdata),
    .readdata   (rdata),
    .VGA_HCOUNT (hcount),
    .VGA_VCOUNT (vcount),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .addr_t     (addr_t),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] shadow_m [8];
  logic [31:0] active_m [8];
  bit          pending_m;
  int          frame_m;
  logic [31:0] rd_m;
  logic [18:0] p1_m, out_m;   // {hit, idx[2:0], addr[14:0]}

  // Scan the active sprites in index order; the first one whose box contains
  // the pixel wins.
  function automatic logic [18:0] pixel_model(input int h, input int v);
    logic [31:0] w;
    int x, y, img;
    for (int i = 0; i < 8; i++) begin
      w = active_m[i];
      x = int'(w[19:10]);
      y = int'(w[9:0]);
      img = int'(w[24:20]);
      if (w[31] && h >= x && h < x + 32 && v >= y && v < y + 32)
        return {1'b1, 3'(i), 15'(img * 1024 + (v - y) * 32 + (h - x))};
    end
    return 19'd0;
  endfunction

  function automatic logic [31:0] read_model(input int a);
    if (a < 8) return shadow_m[a];
    if (a == 8) return 32'(frame_m * 256 + int'(pending_m));
    return 32'd0;
  endfunction

  initial begin
    bit s_rst, s_cs, s_wr, s_rd, vb;
    int s_a, s_h, s_v;
    logic [31:0] s_wd;
    forever begin
      @(posedge clk);
      s_rst = reset; s_cs = cs; s_wr = wr; s_rd = rd;
      s_a = int'(addr); s_wd = wdata; s_h = int'(hcount); s_v = int'(vcount);
      if (s_rst) begin
        for (int i = 0; i < 8; i++) begin
          shadow_m[i] = 32'd0;
          active_m[i] = 32'd0;
        end
        pending_m = 0; frame_m = 0; rd_m = 32'd0; p1_m = 19'd0; out_m = 19'd0;
      end else begin
        out_m = p1_m;
        p1_m  = pixel_model(s_h, s_v);
        if (s_cs && s_rd) rd_m = read_model(s_a);
        vb = (s_v == 480) && (s_h == 0);
        if (vb) begin
          frame_m = (frame_m + 1) % 256;
          if (pending_m) begin
            for (int i = 0; i < 8; i++) active_m[i] = shadow_m[i];
            pending_m = 0;
          end
        end
        if (s_cs && s_wr) begin
          if (s_a < 8) shadow_m[s_a] = s_wd & 32'h81FF_FFFF;
          else if (s_a == 8 && s_wd[0]) pending_m = 1;
        end
      end
      #1;
      check("m_readdata", rdata, rd_m);
      check("m_frame_cnt", 32'(frame_cnt), 32'(frame_m));
      check("m_hit", 32'(hit), 32'(out_m[18]));
      check("m_hit_idx", 32'(hit_idx), 32'(out_m[17:15]));
      check("m_addr_t", 32'(addr_t), 32'(out_m[14:0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic park();
    cs = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
    hcount = 10'(PARK_H); vcount = 10'(PARK_V);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input bit at_vblank);
    @(negedge clk);
    cs = 1; wr = 1; addr = a; wdata = d;
    if (at_vblank) begin hcount = 10'd0; vcount = 10'd480; end
    $display("write addr=%0d data=%h vblank=%0d", a, d, at_vblank);
    @(negedge clk);
    park();
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    cs = 1; rd = 1; addr = a;
    @(negedge clk);
    park();
    $display("read  addr=%0d data=%h", a, rdata);
    check(name, rdata, exp);
  endtask

  task automatic vblank();
    @(negedge clk);
    hcount = 10'd0; vcount = 10'd480;
    @(negedge clk);
    park();
    $display("vblank frame_cnt=%0d", frame_cnt);
  endtask

  task automatic pixel(input int h, input int v, input bit eh, input logic [2:0] ei,
                       input logic [14:0] ea, input string name);
    @(negedge clk);
    hcount = 10'(h); vcount = 10'(v);
    @(negedge clk);
    @(negedge clk);
    $display("pixel (%0d,%0d) hit=%0d idx=%0d addr_t=%h", h, v, hit, hit_idx, addr_t);
    check({name, "_hit"}, 32'(hit), 32'(eh));
    check({name, "_idx"}, 32'(hit_idx), 32'(ei));
    check({name, "_addr"}, 32'(addr_t), 32'(ea));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; park();
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_readdata", rdata, 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_addr_t", 32'(addr_t), 32'd0);

    // Slot 0: en, img 3, x 100, y 50, with junk in the reserved bits.
    bus_wr(4'd0, 32'hFE31_9032, 0);
    bus_rd(4'd0, 32'h8031_9032, "slot0_mask");
    bus_wr(4'd8, 32'd1, 0);
    bus_rd(4'd8, 32'h0000_0001, "ctrl_pending");
    pixel(100, 50, 0, 3'd0, 15'h0000, "pre_commit");
    vblank();
    bus_rd(4'd8, 32'h0000_0100, "ctrl_committed");
    pixel(100, 50, 1, 3'd0, 15'h0C00, "corner_tl");
    pixel(131, 81, 1, 3'd0, 15'h0FFF, "corner_br");
    pixel(132, 81, 0, 3'd0, 15'h0000, "right_edge");
    pixel(99, 50, 0, 3'd0, 15'h0000, "left_edge");

    // Overlapping slots 2 (img 7) and 5 (img 9) at (200,200).
    bus_wr(4'd2, 32'h8073_20C8, 0);
    bus_wr(4'd5, 32'h8093_20C8, 0);
    bus_wr(4'd8, 32'd1, 0);
    vblank();
    pixel(210, 210, 1, 3'd2, 15'h1D4A, "prio_low");
    bus_wr(4'd2, 32'h0073_20C8, 0);
    bus_wr(4'd8, 32'd1, 0);
    pixel(210, 210, 1, 3'd2, 15'h1D4A, "prio_held");
    vblank();
    pixel(210, 210, 1, 3'd5, 15'h254A, "prio_next");

    // Slot 1 written without a commit stays invisible.
    bus_wr(4'd1, 32'h8014_B12C, 0);
    for (int k = 0; k < 3; k++) begin
      vblank();
      pixel(305, 305, 0, 3'd0, 15'h0000, "no_commit");
    end
    bus_rd(4'd8, 32'h0000_0600, "ctrl_no_commit");
    check("frame_plus3", 32'(frame_cnt), 32'd6);

    // Slot 4 old value at (400,100), img 2.
    bus_wr(4'd4, 32'h8026_4064, 0);
    bus_wr(4'd8, 32'd1, 0);
    vblank();
    pixel(405, 105, 1, 3'd4, 15'h08A5, "slot4_old");
    pixel(305, 305, 1, 3'd1, 15'h04A5, "slot1_late");
    // Shadow write lands on the commit edge: active keeps the old value.
    bus_wr(4'd8, 32'd1, 0);
    bus_wr(4'd4, 32'h8027_0864, 1);
    pixel(405, 105, 1, 3'd4, 15'h08A5, "coinc_old");
    pixel(455, 105, 0, 3'd0, 15'h0000, "coinc_new_absent");
    bus_rd(4'd8, 32'h0000_0800, "ctrl_cleared");
    // CTRL request on the commit edge wins over the clear.
    bus_wr(4'd8, 32'd1, 0);
    bus_wr(4'd8, 32'd1, 1);
    bus_rd(4'd8, 32'h0000_0901, "ctrl_new_wins");
    pixel(455, 105, 1, 3'd4, 15'h08A5, "slot4_new");
    pixel(405, 105, 0, 3'd0, 15'h0000, "slot4_old_gone");
    vblank();
    bus_rd(4'd8, 32'h0000_0A00, "ctrl_applied");

    // Sprite past the right edge: no wrap to the left of the raster.
    bus_wr(4'd6, 32'h8019_D800, 0);
    bus_wr(4'd8, 32'd1, 0);
    vblank();
    pixel(5, 0, 0, 3'd0, 15'h0000, "no_wrap");
    pixel(635, 0, 1, 3'd6, 15'h0405, "clip_visible");
    bus_wr(4'd12, 32'hFFFF_FFFF, 0);
    bus_rd(4'd12, 32'd0, "rd_addr12");
    bus_rd(4'd9, 32'd0, "rd_addr9");
    bus_rd(4'd15, 32'd0, "rd_addr15");

    // Reset on a commit edge with a write pending.
    bus_wr(4'd8, 32'd1, 0);
    @(negedge clk);
    reset = 1; cs = 1; wr = 1; addr = 4'd0; wdata = 32'hFFFF_FFFF;
    hcount = 10'd0; vcount = 10'd480;
    $display("reset on commit edge");
    @(negedge clk);
    reset = 0; park();
    check("rst2_readdata", rdata, 32'd0);
    check("rst2_frame", 32'(frame_cnt), 32'd0);
    check("rst2_hit", 32'(hit), 32'd0);
    check("rst2_idx", 32'(hit_idx), 32'd0);
    bus_rd(4'd0, 32'd0, "rst2_slot0");
    bus_rd(4'd8, 32'd0, "rst2_ctrl");
    pixel(100, 50, 0, 3'd0, 15'h0000, "rst2_pixel");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
